// File: rtl/cpu_sequencer_if.sv
// Datapath-side bundle of the mini-CPU sequencer: register-memory ports, ALU control
// and the LCD refresh handshake.
interface cpu_sequencer_if;
    logic [3:0] rd_addr1;
    logic [3:0] rd_addr2;
    logic [3:0] wr_addr;
    logic       wr_en;
    logic       wr_zero;
    logic [2:0] alu_op;
    logic       alu_imm_sign;
    logic [5:0] alu_imm;
    logic       alu_en;
    logic       lcd_req;
    logic       lcd_ack;

    modport master (
        output rd_addr1, rd_addr2, wr_addr, wr_en, wr_zero,
        output alu_op, alu_imm_sign, alu_imm, alu_en, lcd_req,
        input  lcd_ack
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_addr, wr_en, wr_zero,
        input  alu_op, alu_imm_sign, alu_imm, alu_en, lcd_req,
        output lcd_ack
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Mini-CPU control unit: debounces the power/send buttons, latches an instruction and walks it
// through decode/execute/writeback/display, including the multi-cycle CLEAR sweep.
module cpu_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int NUM_REGS        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ligar,
    input  logic                   enviar,
    input  logic [2:0]             opcode,
    input  logic [3:0]             addr1,
    input  logic [3:0]             addr2,
    input  logic [6:0]             addr3OuImm,
    output logic                   cpu_on,
    output logic [2:0]             state_o,
    cpu_sequencer_if.master        bus
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int CLR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        OFF       = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4,
        CLEAR     = 3'd5,
        DISPLAY   = 3'd6
    } state_t;

    // Bit 0 = ligar, bit 1 = enviar. Buttons idle high (released).
    logic [1:0]       btn_raw;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       db_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [1:0]       accept;
    logic [1:0]       release_w;
    logic             lig_rel;
    logic             env_rel;

    assign btn_raw = {enviar, ligar};

    // NOTE: every signal driven from always_comb gets a default on entry, otherwise a path
    // that skips the assignment silently infers a latch.
    always_comb begin
        accept    = '0;
        release_w = '0;
        for (int i = 0; i < 2; i++) begin
            accept[i]    = (sync2_q[i] != db_q[i]) && (cnt_q[i] == CNT_MAX);
            release_w[i] = accept[i] & sync2_q[i];
        end
    end

    assign lig_rel = release_w[0];
    assign env_rel = release_w[1];

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            db_q    <= 2'b11;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (accept[i]) begin
                    db_q[i]  <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    state_t           state_q;
    logic             pending_q;
    logic [3:0]       addr1_q;
    logic [CLR_W-1:0] clr_q;
    logic [3:0]       rd_addr1_q;
    logic [3:0]       rd_addr2_q;
    logic [3:0]       wr_addr_q;
    logic             wr_en_q;
    logic             wr_zero_q;
    logic [2:0]       alu_op_q;
    logic             alu_imm_sign_q;
    logic [5:0]       alu_imm_q;
    logic             alu_en_q;
    logic             lcd_req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= OFF;
            pending_q      <= 1'b0;
            addr1_q        <= '0;
            clr_q          <= '0;
            rd_addr1_q     <= '0;
            rd_addr2_q     <= '0;
            wr_addr_q      <= '0;
            wr_en_q        <= 1'b0;
            wr_zero_q      <= 1'b0;
            alu_op_q       <= '0;
            alu_imm_sign_q <= 1'b0;
            alu_imm_q      <= '0;
            alu_en_q       <= 1'b0;
            lcd_req_q      <= 1'b0;
        end else begin
            wr_en_q   <= 1'b0;
            wr_zero_q <= 1'b0;
            alu_en_q  <= 1'b0;

            // Power-off requested mid-instruction is deferred until the instruction finishes.
            if (lig_rel && state_q inside {DECODE, EXECUTE, WRITEBACK, CLEAR, DISPLAY})
                pending_q <= 1'b1;

            case (state_q)
                OFF: begin
                    pending_q <= 1'b0;
                    if (lig_rel) state_q <= FETCH;
                end
                FETCH: begin
                    if (lig_rel) begin
                        state_q <= OFF;
                    end else if (env_rel) begin
                        alu_op_q       <= opcode;
                        addr1_q        <= addr1;
                        alu_imm_sign_q <= addr3OuImm[6];
                        alu_imm_q      <= addr3OuImm[5:0];
                        rd_addr1_q     <= addr2;
                        rd_addr2_q     <= addr3OuImm[6:3];
                        state_q        <= DECODE;
                    end
                end
                DECODE: begin
                    if (alu_op_q == 3'b110) begin
                        state_q   <= CLEAR;
                        clr_q     <= '0;
                        wr_en_q   <= 1'b1;
                        wr_zero_q <= 1'b1;
                        wr_addr_q <= '0;
                    end else if (alu_op_q == 3'b111) begin
                        state_q    <= DISPLAY;
                        rd_addr1_q <= addr1_q;
                        lcd_req_q  <= 1'b1;
                    end else begin
                        state_q  <= EXECUTE;
                        alu_en_q <= 1'b1;
                    end
                end
                EXECUTE: begin
                    state_q   <= WRITEBACK;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= addr1_q;
                end
                WRITEBACK: begin
                    state_q    <= DISPLAY;
                    rd_addr1_q <= addr1_q;
                    lcd_req_q  <= 1'b1;
                end
                CLEAR: begin
                    if (clr_q == CLR_LAST) begin
                        state_q    <= DISPLAY;
                        rd_addr1_q <= addr1_q;
                        lcd_req_q  <= 1'b1;
                    end else begin
                        clr_q     <= clr_q + 1'b1;
                        wr_en_q   <= 1'b1;
                        wr_zero_q <= 1'b1;
                        wr_addr_q <= 4'(clr_q + 1'b1);
                    end
                end
                DISPLAY: begin
                    if (bus.lcd_ack) begin
                        lcd_req_q <= 1'b0;
                        if (pending_q || lig_rel) begin
                            state_q   <= OFF;
                            pending_q <= 1'b0;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                default: state_q <= OFF;
            endcase
        end
    end

    assign cpu_on           = (state_q != OFF);
    assign state_o          = state_q;
    assign bus.rd_addr1     = rd_addr1_q;
    assign bus.rd_addr2     = rd_addr2_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_zero      = wr_zero_q;
    assign bus.alu_op       = alu_op_q;
    assign bus.alu_imm_sign = alu_imm_sign_q;
    assign bus.alu_imm      = alu_imm_q;
    assign bus.alu_en       = alu_en_q;
    assign bus.lcd_req      = lcd_req_q;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Control unit for the mini-CPU datapath: the 16x16 register memory, the ALU and the LCD.
- Conditions the raw active-low `ligar`/`enviar` pushbuttons (sync + debounce + release detect) and latches the instruction switches on an `enviar` release.
- Sequences each instruction through decode/execute/writeback/display, driving memory read/write addresses, write enable, ALU opcode/immediate and the LCD request handshake.
- Owns power on/off and the multi-cycle CLEAR sweep.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive identical synchronized samples required to accept a new button level.
- NUM_REGS, 16, register count swept by CLEAR (power of two, addresses 0..NUM_REGS-1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ligar  input  1  raw power button, active-low (pressed=0)
- enviar  input  1  raw send button, active-low
- opcode  input  3  instruction switches
- addr1  input  4  destination / display address switches
- addr2  input  4  source A address switches
- addr3OuImm  input  7  source B address in [6:3], or immediate ([6]=sign, [5:0]=magnitude)
- lcd_ack  input  1  LCD finished refresh
- cpu_on  output  1  high when not OFF
- state_o  output  3  current state encoding
- rd_addr1  output  4  memory read port 1 address
- rd_addr2  output  4  memory read port 2 address
- wr_addr  output  4  memory write address
- wr_en  output  1  memory write strobe, one cycle
- wr_zero  output  1  write data forced to 0 (CLEAR)
- alu_op  output  3  latched opcode to ALU
- alu_imm_sign  output  1  latched immediate sign
- alu_imm  output  6  latched immediate magnitude
- alu_en  output  1  ALU result register load, one cycle
- lcd_req  output  1  LCD refresh request, held until ack

Behaviour:
- Reset (async, rst_n=0): state=OFF; all outputs 0; debounced levels=1 (released); instruction latch cleared; power-off-pending cleared.
- Button path, per button: 2-FF synchronizer, then a counter. Debounced level changes only after DEBOUNCE_CYCLES consecutive samples differ from it. "Release" is a one-cycle pulse on debounced 0->1.
- States: OFF=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, CLEAR=5, DISPLAY=6.
- OFF: ligar release -> FETCH. enviar ignored.
- FETCH: enviar release latches opcode, addr1, addr2, addr3OuImm -> DECODE.
  - ligar release -> OFF.
  - Both releases in the same cycle: ligar wins; the instruction is discarded.
- DECODE (1 cycle): rd_addr1=latched addr2, rd_addr2=latched addr3OuImm[6:3].
  - Opcode 110 -> CLEAR, clear counter=0.
  - Opcode 111 -> DISPLAY with rd_addr1=latched addr1.
  - Otherwise -> EXECUTE.
- EXECUTE (1 cycle): alu_en=1 -> WRITEBACK.
- WRITEBACK (1 cycle): wr_en=1, wr_addr=latched addr1 -> DISPLAY with rd_addr1=addr1.
  - Data is the ALU result. Opcodes: LOAD=imm, ADD=A+B, ADDI=A+imm, SUB=A-B, SUBI=A-imm, MUL=A*B[15:0]. The ALU computes; this block only sequences.
- CLEAR: one write per cycle, wr_en=1, wr_zero=1, wr_addr=counter. Counter increments each cycle.
  - After writing NUM_REGS-1 -> DISPLAY (rd_addr1=addr1).
  - Takes exactly NUM_REGS cycles.
- DISPLAY: lcd_req=1 from entry until a cycle with lcd_ack=1.
  - On that cycle lcd_req drops and state -> FETCH (or OFF if power-off pending).
  - lcd_ack outside DISPLAY is ignored.
- ligar release in DECODE..DISPLAY sets power-off-pending. The instruction completes atomically, and the next FETCH-entry goes to OFF instead. Pending clears on entering OFF.
- enviar releases outside FETCH are dropped, not queued.
- Latched instruction fields are stable from DECODE until the next FETCH latch; switch changes mid-instruction have no effect.
- Outputs are registered. wr_en, alu_en and wr_zero are 0 in every state not listed above.
- rst_n asserted mid-instruction or mid-CLEAR aborts immediately to OFF; no further wr_en.

Test Plan:
- DEBOUNCE_CYCLES=4, reset, ligar pulse of 3 cycles low -> no state change. ligar low 10 cycles then high -> state OFF->FETCH exactly 2+4 cycles after the rising edge, cpu_on=1.
- In FETCH, opcode=001, addr1=5, addr2=2, addr3OuImm=7'b0011000, enviar release -> DECODE(rd 2,3), EXECUTE(alu_en), WRITEBACK(wr_en, wr_addr=5), DISPLAY lcd_req=1. lcd_ack after 7 cycles -> FETCH; wr_en pulses exactly once.
- opcode=110 -> 16 consecutive wr_en cycles with wr_addr 0..15 and wr_zero=1, then DISPLAY.
- opcode=111, addr1=9 -> no wr_en, no alu_en, rd_addr1=9, lcd_req held until ack.
- ligar release during EXECUTE of ADDI -> writeback and display still occur; after lcd_ack state=OFF, not FETCH. enviar release during DISPLAY -> ignored; state stays FETCH afterward with no new DECODE.
- rst_n low during CLEAR at counter=6 -> immediate OFF, all outputs 0, no further writes; simultaneous ligar+enviar release in FETCH -> OFF, instruction not latched.
